// File: rtl/gb_int_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, int_n generation
// and the acknowledge sequence that clears a source and yields its vector.
module gb_int_ctrl #(
  parameter int          NUM_IRQ = 5,
  parameter logic [15:0] ADDR_IF = 16'hFF0F,
  parameter logic [15:0] ADDR_IE = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_in,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               int_ack,
  output logic [7:0]         data_out,
  output logic               data_oe,
  output logic               int_n,
  output logic [7:0]         vector,
  output logic               vector_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [NUM_IRQ-1:0] r_if;
  logic [7:0]         r_ie;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic               r_wr_q;
  logic               r_rd_q;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_low;
  logic [NUM_IRQ-1:0] w_ack_clr;
  logic [NUM_IRQ-1:0] w_if_nxt;
  logic [7:0]         w_vec;
  logic               w_wr;
  logic               w_rd_fall;
  logic               w_sel_if;
  logic               w_sel_ie;
  logic               w_vec_ld;
  logic               w_vv_clr;

  assign w_sel_if  = (addr == ADDR_IF);
  assign w_sel_ie  = (addr == ADDR_IE);
  // Strobe edges make one access per CPU cycle
  // even when the CPU runs on a divided clock.
  assign w_wr      = ~wr_n & r_wr_q;
  assign w_rd_fall = ~rd_n & r_rd_q;
  assign w_rise    = irq_req & ~r_irq_q;
  assign w_pend    = r_if & r_ie[NUM_IRQ-1:0];
  assign w_low     = w_pend & (~w_pend + NUM_IRQ'(1));

  always_comb begin
    w_vec = 8'h40;
    unique case (1'b1)
      w_low[0]: w_vec = 8'h40;
      w_low[1]: w_vec = 8'h48;
      w_low[2]: w_vec = 8'h50;
      w_low[3]: w_vec = 8'h58;
      w_low[4]: w_vec = 8'h60;
      default:  w_vec = 8'h40;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_ack_clr = '0;
    w_vec_ld  = 1'b0;
    w_vv_clr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (int_ack && (|w_pend)) begin
          w_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_ack_clr = w_low;
        w_vec_ld  = |w_pend;
        w_nxt     = (|w_pend) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (w_rd_fall) begin
          w_nxt    = S_IDLE;
          w_vv_clr = 1'b1;
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  // Clear first, then CPU write, then rising requests:
  // a new request always wins, and a written 1 survives the clear.
  always_comb begin
    w_if_nxt = r_if & ~w_ack_clr;
    if (w_wr && w_sel_if) begin
      w_if_nxt = data_in[NUM_IRQ-1:0];
    end
    w_if_nxt = w_if_nxt | w_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if    <= '0;
      r_ie    <= 8'h00;
      r_irq_q <= '0;
      r_wr_q  <= 1'b0;
      r_rd_q  <= 1'b0;
    end else begin
      r_if    <= w_if_nxt;
      r_irq_q <= irq_req;
      r_wr_q  <= wr_n;
      r_rd_q  <= rd_n;
      if (w_wr && w_sel_ie) begin
        r_ie <= data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_n <= 1'b1;
    end else begin
      int_n <= ~(|w_pend);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end else begin
      data_oe <= ~rd_n & (w_sel_if | w_sel_ie);
      if (~rd_n && w_sel_if) begin
        data_out <= {3'b111, r_if};
      end else if (~rd_n && w_sel_ie) begin
        data_out <= r_ie;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector       <= 8'h00;
      vector_valid <= 1'b0;
    end else begin
      if (w_vec_ld) begin
        vector       <= w_vec;
        vector_valid <= 1'b1;
      end else if (w_vv_clr) begin
        vector_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gb_int_ctrl.md
Name: gb_int_ctrl

Overview:
- Game Boy interrupt controller on the CPU bus, directly upstream of the CPU core.
- Latches the five peripheral interrupt requests into IF (0xFF0F) and masks them with IE (0xFFFF).
- Drives the CPU's active-low int_n.
- On a CPU acknowledge, selects the highest-priority pending source, clears it, and presents the restart vector.

Parameters:
- NUM_IRQ, 5, number of request sources (bit 0 VBlank, 1 LCD STAT, 2 Timer, 3 Serial, 4 Joypad); only 5 supported.
- ADDR_IF, 16'hFF0F, IF register address.
- ADDR_IE, 16'hFFFF, IE register address.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- addr  input  16  CPU address bus
- data_in  input  8  CPU write data (CPU data_out)
- rd_n  input  1  CPU read strobe, active-low
- wr_n  input  1  CPU write strobe, active-low
- irq_req  input  5  peripheral request levels, synchronous to clk
- int_ack  input  1  one-clk acknowledge pulse from CPU interrupt sequence
- data_out  output  8  register read data
- data_oe  output  1  high when data_out must drive the CPU data_in mux
- int_n  output  1  low while (IF & IE & 5'h1F) != 0
- vector  output  8  restart address of last acknowledged source
- vector_valid  output  1  high from the cycle after an accepted ack until the next rd_n falling edge

Behaviour:
- Reset values:
  - IF=5'h00, IE=8'h00, int_n=1, data_out=8'h00, data_oe=0.
  - vector=8'h00, vector_valid=0, edge-detect history registers=0.
- Request capture:
  - Each irq_req bit is rising-edge detected against a registered copy.
  - A rise sets the matching IF bit on the next clk edge.
  - A level held high sets the bit only once.
- Bus write:
  - A write is detected when wr_n is 0 this clk and 1 the previous clk, giving one write per CPU strobe regardless of the CPU's divided clock.
  - At addr==ADDR_IF, IF <= data_in[4:0]. At addr==ADDR_IE, IE <= data_in (all 8 bits stored).
  - Other addresses are ignored.
- Bus read (registered, 1-clk latency):
  - When rd_n==0 and addr matches, data_oe<=1 next clk; otherwise data_oe<=0.
  - IF reads as {3'b111, IF}. IE reads as stored 8 bits.
  - data_out holds its last value when data_oe=0.
- int_n:
  - Registered: int_n <= ~|(IF & IE[4:0]). Reflects register state with 1 clk delay.
  - No IME inside this block; IME lives in the CPU.
- Acknowledge FSM (states IDLE, ACK, HOLD):
  - IDLE: on int_ack with pending=(IF & IE[4:0]) nonzero, go to ACK. An int_ack with pending==0 is ignored and stays in IDLE (vector unchanged).
  - ACK (1 clk):
    - Choose the lowest set pending bit n (priority 0 highest).
    - Clear IF[n]; vector <= 8'h40 + 8*n (40/48/50/58/60); vector_valid <= 1.
    - Then go to HOLD.
  - HOLD: on a rd_n falling edge go to IDLE with vector_valid <= 0. A new int_ack in HOLD is ignored.
- Simultaneous events, same cycle, same bit:
  - Rising request beats CPU write of 0 (bit ends 1).
  - Rising request beats ACK clear (bit ends 1).
  - CPU write of 1 and ACK clear → bit ends 1.
- Ack priority uses the pending value sampled in ACK, not at int_ack.
- Mid-operation reset: rst_n low in any state returns all state to reset values immediately (async); the FSM restarts in IDLE.
- Address decode uses exact 16-bit compare; there is no mirroring.

Test Plan:
- Reset, then read 0xFF0F and 0xFFFF → data_out 8'hE0 and 8'h00 with data_oe one clk after rd_n low; int_n=1.
- IE write 8'h05; pulse irq_req[2] → IF=5'h04, int_n low 2 clks after the rise. Pulse irq_req[1] with IE[1]=0 → IF=5'h06, int_n unchanged.
- IF=5'h1F, IE=8'h1F, int_ack pulse → vector=8'h40, IF=5'h1E. Second ack after rd_n falling edge → vector=8'h48, IF=5'h1C.
- Hold irq_req[0] high for 20 clks → single set. Write IF=0 while held → IF stays 0.
- Same cycle: irq_req[3] rises while the CPU writes IF=0 → IF[3]=1. ACK clears bit 3 while irq_req[3] rises → IF[3]=1.
- int_ack with IE=0 → FSM stays IDLE, vector_valid=0. Assert rst_n low during HOLD → vector_valid=0 and IF=0 immediately.
